adc_reader: RTL and testbench
=============================

Name: adc_reader

Overview:
- SPI master that reads one frame from a dual-channel serial ADC (LTC1407A-style framing) and presents both channel samples in parallel.
- It is the receive-side counterpart of the DAC output path. It shares the board SPI clock pin and uses its own conversion strobe and MISO line.
- Conversions are started on request. Results are held stable until the next frame completes.

Parameters:
- DIV, 50, clk cycles per half-period of spi_sck (DIV >= 1; DIV = 0 is illegal).
- WIDTH, 14, bits per channel sample.
- FRAME, 2*WIDTH+6, sck periods per frame (derived localparam, not overridable).

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  synchronous reset, active-low.
- start  in  1  request a conversion; sampled only in IDLE.
- spi_miso  in  1  serial data from the ADC.
- spi_sck  out  1  SPI clock; idles low.
- ad_conv  out  1  conversion strobe to the ADC.
- busy  out  1  high while a frame is in progress.
- valid  out  1  one-cycle pulse when ch0/ch1 are updated.
- ch0  out  WIDTH  channel 0 sample, raw bits, MSB-first order as received.
- ch1  out  WIDTH  channel 1 sample, raw bits.

Behaviour:
- Reset (rst = 0 at a clk edge), next cycle:
  - state IDLE, divider counter 0, bit counter 0.
  - spi_sck = 0, ad_conv = 0, busy = 0, valid = 0, ch0 = 0, ch1 = 0.
  - Applies mid-frame as well: the frame is abandoned, no valid pulse, registers cleared.
- Divider:
  - Counter runs 0..DIV-1 only outside IDLE and DONE; tick when count = DIV-1, then wraps to 0.
  - Cleared on every entry to CONV.
- State IDLE: start = 1 at cycle t -> CONV at t+1.
- State CONV:
  - ad_conv = 1, busy = 1, spi_sck = 0.
  - Lasts 2 ticks (2*DIV cycles), then SHIFT with ad_conv = 0.
- State SHIFT:
  - Runs FRAME sck periods. The 1st tick of each period drives spi_sck 0->1; the 2nd tick drives it 1->0.
  - spi_miso is registered on the clk edge where spi_sck goes 1->0.
  - Bit index k = 0..FRAME-1, counted per period:
    - k = 2..WIDTH+1 shift into the ch0 shadow register, MSB first.
    - k = WIDTH+4..2*WIDTH+3 shift into the ch1 shadow register, MSB first.
    - All other k are ignored (high-Z bits).
  - After the falling tick of k = FRAME-1 -> DONE.
- State DONE (one cycle):
  - ch0/ch1 <= shadow registers, valid = 1, busy = 0, spi_sck = 0.
  - Next state is IDLE.
- Timing:
  - valid is high exactly at cycle t + 2*DIV*(FRAME+1) + 1.
  - busy is high from t+1 through t + 2*DIV*(FRAME+1).
- Handshake:
  - start while busy or in DONE is ignored, not queued.
  - start held high gives back-to-back frames: DONE -> IDLE -> CONV, with one idle cycle between frames.
- Outputs are registered. ch0/ch1 change only in the DONE cycle.
- spi_sck has no glitches, and ad_conv and spi_sck are never high together.

Decomposition:
- Shared package holds:
  - FRAME formula.
  - Bit-window constants CH0_FIRST = 2 and CH1_FIRST = WIDTH+4.
  - State encoding IDLE/CONV/SHIFT/DONE, which the DAC path may reuse.
- One natural sub-module: spi_sck_div, containing the divider counter, tick generation and sck phase register, with enable/clear inputs. The FSM and shift registers stay in adc_reader.

Test Plan:
- Reset and idle:
  - Stimulus: hold rst = 0 for 5 cycles, then release with start = 0 for 50 cycles.
  - Required: all outputs 0 throughout, spi_sck flat low.
- Single frame:
  - Stimulus: DIV = 2, WIDTH = 14; ADC model drives ch0 = 14'h2A5C and ch1 = 14'h1234 (high-Z bits driven 1); start pulsed at t.
  - Required: valid only at t+141; ch0 = 2A5C, ch1 = 1234; exactly 34 sck rising edges; ad_conv high for 4 cycles.
- Back-to-back:
  - Stimulus: start held high for 3 frames with patterns 0000/3FFF, 3FFF/0000, 1555/2AAA.
  - Required: each valid carries the matching pair; exactly one idle cycle between frames; no extra frame started during DONE.
- Start while busy:
  - Stimulus: pulse start at t+10 and t+100 during a frame.
  - Required: both pulses ignored; single valid at t+141.
- Mid-frame reset:
  - Stimulus: rst = 0 at frame bit k = 10.
  - Required: next cycle sck = 0, busy = 0, ch0 = ch1 = 0, no valid pulse; a subsequent start produces a correct full frame.
- DIV = 1 corner:
  - Stimulus: DIV = 1.
  - Required: sck period 2 clk cycles; valid at t+71; data correct.

Source files
------------

// File: rtl/adc_reader_pkg.sv
// Shared definitions for the serial ADC read path: frame geometry, channel
// bit windows and the state encoding also used by the DAC output path.
package adc_reader_pkg;

    // Sequencer states for a single conversion frame.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CONV  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } state_t;

    // First frame bit carrying channel 0 data (two leading high-Z bits).
    localparam int CH0_FIRST = 2;

    // sck periods in one frame: two samples plus three pairs of high-Z bits.
    function automatic int frame_len(input int width);
        return 2 * width + 6;
    endfunction

    // First frame bit carrying channel 1 data.
    function automatic int ch1_first(input int width);
        return width + 4;
    endfunction

endpackage

// File: rtl/adc_reader_spi_sck_div.sv
// SPI clock divider: a 0..DIV-1 counter producing a tick every DIV enabled
// cycles, plus the registered sck phase that toggles on ticks while the
// caller lets the clock run.
module adc_reader_spi_sck_div #(
    parameter int DIV = 50
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    input  logic sck_run,
    output logic tick,
    output logic sck
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0] cnt_reg;
    logic          sck_reg;

    assign tick = en && (cnt_reg == CW'(DIV - 1));
    assign sck  = sck_reg;

    // Counter wraps on each tick; sck is a plain register so it cannot glitch.
    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else if (clr) begin
            cnt_reg <= '0;
            sck_reg <= 1'b0;
        end else if (en) begin
            cnt_reg <= tick ? '0 : cnt_reg + 1'b1;
            if (tick && sck_run) begin
                sck_reg <= ~sck_reg;
            end
        end
    end

endmodule

// File: rtl/adc_reader.sv
// SPI master reading one dual-channel frame from an LTC1407A-style ADC.
// A start request pulses ad_conv for one sck period, then clocks out a full
// frame, capturing both channel samples; results are held until the next
// frame completes.
module adc_reader
    import adc_reader_pkg::*;
#(
    parameter int DIV   = 50,
    parameter int WIDTH = 14
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             spi_miso,
    output logic             spi_sck,
    output logic             ad_conv,
    output logic             busy,
    output logic             valid,
    output logic [WIDTH-1:0] ch0,
    output logic [WIDTH-1:0] ch1
);

    localparam int FRAME     = frame_len(WIDTH);
    localparam int CH1_FIRST = ch1_first(WIDTH);
    localparam int BW        = $clog2(FRAME);

    state_t           state_reg;
    logic [BW-1:0]    bit_reg;
    logic [WIDTH-1:0] sh0_reg;
    logic [WIDTH-1:0] sh1_reg;
    logic [WIDTH-1:0] ch0_reg;
    logic [WIDTH-1:0] ch1_reg;
    logic             ad_conv_reg;
    logic             busy_reg;
    logic             valid_reg;

    logic div_en;
    logic div_clr;
    logic tick;
    logic sck;
    logic in_ch0;
    logic in_ch1;

    // The divider only runs while a frame is active and restarts at CONV entry.
    assign div_en  = (state_reg == CONV) || (state_reg == SHIFT);
    assign div_clr = (state_reg == IDLE) && start;

    // Which channel window the current frame bit falls in, if any.
    assign in_ch0 = (bit_reg >= BW'(CH0_FIRST)) && (bit_reg < BW'(CH0_FIRST + WIDTH));
    assign in_ch1 = (bit_reg >= BW'(CH1_FIRST)) && (bit_reg < BW'(CH1_FIRST + WIDTH));

    adc_reader_spi_sck_div #(
        .DIV(DIV)
    ) u_spi_sck_div (
        .clk     (clk),
        .rst     (rst),
        .en      (div_en),
        .clr     (div_clr),
        .sck_run (state_reg == SHIFT),
        .tick    (tick),
        .sck     (sck)
    );

    // Frame sequencer: conversion strobe, bit counting, capture and hand-off.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= IDLE;
            bit_reg     <= '0;
            sh0_reg     <= '0;
            sh1_reg     <= '0;
            ch0_reg     <= '0;
            ch1_reg     <= '0;
            ad_conv_reg <= 1'b0;
            busy_reg    <= 1'b0;
            valid_reg   <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        state_reg   <= CONV;
                        bit_reg     <= '0;
                        ad_conv_reg <= 1'b1;
                        busy_reg    <= 1'b1;
                    end
                end
                CONV: begin
                    // bit_reg counts the two strobe ticks here.
                    if (tick) begin
                        if (bit_reg == BW'(1)) begin
                            state_reg   <= SHIFT;
                            bit_reg     <= '0;
                            ad_conv_reg <= 1'b0;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    // Falling-edge tick: sample miso and advance the bit index.
                    if (tick && sck) begin
                        if (in_ch0) begin
                            sh0_reg <= {sh0_reg[WIDTH-2:0], spi_miso};
                        end
                        if (in_ch1) begin
                            sh1_reg <= {sh1_reg[WIDTH-2:0], spi_miso};
                        end
                        if (bit_reg == BW'(FRAME - 1)) begin
                            state_reg <= DONE;
                            bit_reg   <= '0;
                            busy_reg  <= 1'b0;
                            valid_reg <= 1'b1;
                            ch0_reg   <= sh0_reg;
                            ch1_reg   <= sh1_reg;
                        end else begin
                            bit_reg <= bit_reg + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

    assign spi_sck = sck;
    assign ad_conv = ad_conv_reg;
    assign busy    = busy_reg;
    assign valid   = valid_reg;
    assign ch0     = ch0_reg;
    assign ch1     = ch1_reg;

endmodule

// File: tb/tb_adc_reader.sv
// Bench for adc_reader: one instance at DIV=2 and one at DIV=1, each fed by a
// behavioural ADC that serialises a frame image built from the requested pair.
module tb_adc_reader;

    localparam int W  = 14;
    localparam int FR = 2 * W + 6;

    logic clk = 1'b0;
    int   cyc = 0;

    logic [1:0]        rst;
    logic [1:0]        start;
    logic [1:0]        miso = 2'b11;
    logic [1:0]        sck;
    logic [1:0]        adc;
    logic [1:0]        busy;
    logic [1:0]        valid;
    logic [1:0][W-1:0] ch0;
    logic [1:0][W-1:0] ch1;

    // Pattern table per instance, indexed by conversion number.
    logic [W-1:0] pat0 [2][64];
    logic [W-1:0] pat1 [2][64];

    // Observations gathered by the monitor.
    int           conv_n  [2] = '{0, 0};
    int           nv      [2] = '{0, 0};
    int           nbr     [2] = '{0, 0};
    int           nrise   [2] = '{0, 0};
    int           nconvc  [2] = '{0, 0};
    int           nbusy   [2] = '{0, 0};
    int           nover   [2] = '{0, 0};
    int           nnz     [2] = '{0, 0};
    int           vcyc    [2][64];
    int           brise   [2][64];
    logic [W-1:0] v0      [2][64];
    logic [W-1:0] v1      [2][64];
    int           kidx    [2] = '{0, 0};
    logic [FR-1:0] fv     [2];
    logic [1:0]   sck_prev  = 2'b00;
    logic [1:0]   adc_prev  = 2'b00;
    logic [1:0]   busy_prev = 2'b00;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    adc_reader #(.DIV(2), .WIDTH(W)) u_dut_div2 (
        .clk(clk), .rst(rst[0]), .start(start[0]), .spi_miso(miso[0]),
        .spi_sck(sck[0]), .ad_conv(adc[0]), .busy(busy[0]), .valid(valid[0]),
        .ch0(ch0[0]), .ch1(ch1[0])
    );

    adc_reader #(.DIV(1), .WIDTH(W)) u_dut_div1 (
        .clk(clk), .rst(rst[1]), .start(start[1]), .spi_miso(miso[1]),
        .spi_sck(sck[1]), .ad_conv(adc[1]), .busy(busy[1]), .valid(valid[1]),
        .ch0(ch0[1]), .ch1(ch1[1])
    );

    // ADC model and monitor. The ADC presents frame bit 0 once the strobe
    // rises and moves to the next bit after every sck falling edge; high-Z
    // bits read as 1.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (adc[i] && !adc_prev[i]) begin
                conv_n[i]++;
                kidx[i] = 0;
                if (conv_n[i] <= 64)
                    fv[i] = {2'b11, pat0[i][conv_n[i]-1], 2'b11, pat1[i][conv_n[i]-1], 2'b11};
            end
            if (!sck[i] && sck_prev[i]) kidx[i]++;
            miso[i] = (kidx[i] < FR) ? fv[i][FR-1-kidx[i]] : 1'b1;
            if (sck[i] && !sck_prev[i]) nrise[i]++;
            if (adc[i] === 1'b1) nconvc[i]++;
            if (busy[i] === 1'b1) nbusy[i]++;
            if (adc[i] === 1'b1 && sck[i] === 1'b1) nover[i]++;
            if (sck[i] === 1'b1 || adc[i] === 1'b1 || busy[i] === 1'b1 || valid[i] === 1'b1 ||
                ch0[i] !== '0 || ch1[i] !== '0) nnz[i]++;
            if (busy[i] && !busy_prev[i]) begin
                if (nbr[i] < 64) brise[i][nbr[i]] = cyc;
                nbr[i]++;
            end
            if (valid[i] === 1'b1) begin
                if (nv[i] < 64) begin
                    vcyc[i][nv[i]] = cyc;
                    v0[i][nv[i]]   = ch0[i];
                    v1[i][nv[i]]   = ch1[i];
                end
                nv[i]++;
            end
        end
        sck_prev  = sck;
        adc_prev  = adc;
        busy_prev = busy;
    end

    task automatic chk(input string tag, input longint obs, input longint exp);
        n_chk++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
        end
    endtask

    task automatic tick_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns at negedge+1 once a new valid has been seen or the budget ran out.
    task automatic wait_valid(input int i, input int base, input int budget, input string tag);
        for (int k = 0; k < budget; k++) begin
            @(negedge clk);
            #1;
            if (nv[i] > base) break;
        end
        chk({tag, " valid_seen"}, (nv[i] > base) ? 1 : 0, 1);
    endtask

    // One requested frame with full timing and data checks; entered and left
    // one time unit after a rising clock edge.
    task automatic run_frame(input int i, input int div, input logic [W-1:0] a,
                             input logic [W-1:0] b, input string tag);
        int t, lat, b_nv, b_rise, b_conv, b_busy, b_over;
        pat0[i][conv_n[i]] = a;
        pat1[i][conv_n[i]] = b;
        b_nv = nv[i]; b_rise = nrise[i]; b_conv = nconvc[i];
        b_busy = nbusy[i]; b_over = nover[i];
        lat = 2 * div * (FR + 1) + 1;
        start[i] = 1'b1;
        t = cyc;
        tick_n(1);
        start[i] = 1'b0;
        wait_valid(i, b_nv, lat + 40, tag);
        tick_n(1);
        chk({tag, " valid_cycle"}, vcyc[i][b_nv] - t, lat);
        chk({tag, " ch0"}, v0[i][b_nv], a);
        chk({tag, " ch1"}, v1[i][b_nv], b);
        chk({tag, " sck_rises"}, nrise[i] - b_rise, FR);
        chk({tag, " conv_cycles"}, nconvc[i] - b_conv, 2 * div);
        chk({tag, " busy_cycles"}, nbusy[i] - b_busy, 2 * div * (FR + 1));
        chk({tag, " conv_sck_overlap"}, nover[i] - b_over, 0);
        tick_n(5);
        chk({tag, " valid_count"}, nv[i] - b_nv, 1);
        chk({tag, " ch0_held"}, ch0[i], a);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t, nz0, nz1, b_nv, b_br;
        logic [W-1:0] ra, rb;

        // Reset, then idle.
        rst   = 2'b00;
        start = 2'b00;
        tick_n(1);
        nz0 = nnz[0];
        nz1 = nnz[1];
        tick_n(4);
        chk("reset sck", sck[0], 0);
        chk("reset ad_conv", adc[0], 0);
        chk("reset busy", busy[0], 0);
        chk("reset valid", valid[0], 0);
        chk("reset ch0", ch0[0], 0);
        chk("reset ch1", ch1[1], 0);
        rst = 2'b11;
        tick_n(50);
        chk("idle outputs_div2", nnz[0] - nz0, 0);
        chk("idle outputs_div1", nnz[1] - nz1, 0);

        // Single frame, DIV=2.
        run_frame(0, 2, 14'h2A5C, 14'h1234, "single_div2");

        // DIV=1 corner.
        run_frame(1, 1, 14'h2A5C, 14'h1234, "single_div1");

        // Random frames on both instances.
        for (int n = 0; n < 3; n++) begin
            ra = 14'($urandom_range(0, 16383));
            rb = 14'($urandom_range(0, 16383));
            run_frame(0, 2, ra, rb, "random_div2");
            ra = 14'($urandom_range(0, 16383));
            rb = 14'($urandom_range(0, 16383));
            run_frame(1, 1, ra, rb, "random_div1");
        end

        // Back-to-back frames with start held high.
        pat0[0][conv_n[0]]     = 14'h0000; pat1[0][conv_n[0]]     = 14'h3FFF;
        pat0[0][conv_n[0] + 1] = 14'h3FFF; pat1[0][conv_n[0] + 1] = 14'h0000;
        pat0[0][conv_n[0] + 2] = 14'h1555; pat1[0][conv_n[0] + 2] = 14'h2AAA;
        b_nv = nv[0];
        b_br = nbr[0];
        start[0] = 1'b1;
        t = cyc;
        wait_valid(0, b_nv, 200, "b2b frame1");
        wait_valid(0, b_nv + 1, 200, "b2b frame2");
        wait_valid(0, b_nv + 2, 200, "b2b frame3");
        start[0] = 1'b0;
        chk("b2b first_valid", vcyc[0][b_nv] - t, 141);
        chk("b2b spacing12", vcyc[0][b_nv + 1] - vcyc[0][b_nv], 142);
        chk("b2b spacing23", vcyc[0][b_nv + 2] - vcyc[0][b_nv + 1], 142);
        chk("b2b restart_after_idle", brise[0][b_br + 1] - vcyc[0][b_nv], 2);
        chk("b2b f1 ch0", v0[0][b_nv], 14'h0000);
        chk("b2b f1 ch1", v1[0][b_nv], 14'h3FFF);
        chk("b2b f2 ch0", v0[0][b_nv + 1], 14'h3FFF);
        chk("b2b f2 ch1", v1[0][b_nv + 1], 14'h0000);
        chk("b2b f3 ch0", v0[0][b_nv + 2], 14'h1555);
        chk("b2b f3 ch1", v1[0][b_nv + 2], 14'h2AAA);
        tick_n(300);
        chk("b2b frame_count", nv[0] - b_nv, 3);
        chk("b2b busy_rises", nbr[0] - b_br, 3);

        // Start pulses while busy are ignored.
        pat0[0][conv_n[0]] = 14'h0F0F;
        pat1[0][conv_n[0]] = 14'h30C3;
        b_nv = nv[0];
        b_br = nbr[0];
        start[0] = 1'b1;
        t = cyc;
        tick_n(1);
        start[0] = 1'b0;
        tick_n(9);
        start[0] = 1'b1;
        tick_n(1);
        start[0] = 1'b0;
        tick_n(89);
        start[0] = 1'b1;
        tick_n(1);
        start[0] = 1'b0;
        wait_valid(0, b_nv, 100, "busy_start");
        chk("busy_start valid_cycle", vcyc[0][b_nv] - t, 141);
        chk("busy_start ch0", v0[0][b_nv], 14'h0F0F);
        chk("busy_start ch1", v1[0][b_nv], 14'h30C3);
        tick_n(300);
        chk("busy_start valid_count", nv[0] - b_nv, 1);
        chk("busy_start frame_count", nbr[0] - b_br, 1);

        // Reset in the middle of frame bit 10.
        pat0[0][conv_n[0]] = 14'h1111;
        pat1[0][conv_n[0]] = 14'h2222;
        b_nv = nv[0];
        start[0] = 1'b1;
        t = cyc;
        tick_n(1);
        start[0] = 1'b0;
        tick_n((t + 2 * 2 + 1 + 10 * 4 + 1) - cyc);
        chk("midrst in_frame", busy[0], 1);
        rst[0] = 1'b0;
        tick_n(1);
        chk("midrst sck", sck[0], 0);
        chk("midrst busy", busy[0], 0);
        chk("midrst ad_conv", adc[0], 0);
        chk("midrst ch0", ch0[0], 0);
        chk("midrst ch1", ch1[0], 0);
        rst[0] = 1'b1;
        tick_n(200);
        chk("midrst no_valid", nv[0] - b_nv, 0);
        run_frame(0, 2, 14'h3C5A, 14'h05A3, "after_midrst");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
